// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences RV32M divide/remainder ops onto an AXI-Stream divider core,
// resolving divide-by-zero and signed overflow locally without a core request.
module div_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              flush,
    output logic              stall,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_result,
    output logic              div_signed,
    output logic              div_dividend_tvalid,
    output logic              div_divisor_tvalid,
    output logic [XLEN-1:0]   div_dividend_tdata,
    output logic [XLEN-1:0]   div_divisor_tdata,
    input  logic              div_dividend_tready,
    input  logic              div_divisor_tready,
    input  logic              div_dout_tvalid,
    input  logic [2*XLEN-1:0] div_dout_tdata
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic            rem_q, signed_q, dvd_vld_q, dvs_vld_q;
    logic            capture, b_zero, overflow, dvd_left, dvs_left, hs_done, drain;
    logic [XLEN-1:0] special_res, core_res;

    assign capture     = (state_q == IDLE) && ex_valid && funct3[2] && !flush;
    assign b_zero      = (b == '0);
    assign overflow    = !funct3[0] && (a == MIN_INT) && (b == '1);
    assign special_res = b_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
    assign dvd_left    = dvd_vld_q && !div_dividend_tready;
    assign dvs_left    = dvs_vld_q && !div_divisor_tready;
    assign hs_done     = !dvd_left && !dvs_left;
    assign drain       = flush || (state_q == DRAIN);
    assign core_res    = rem_q ? div_dout_tdata[2*XLEN-1:XLEN] : div_dout_tdata[XLEN-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            rem_q     <= 1'b0;
            signed_q  <= 1'b0;
            dvd_vld_q <= 1'b0;
            dvs_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (capture) begin
                    a_q      <= a;
                    b_q      <= b;
                    rem_q    <= funct3[1];
                    signed_q <= !funct3[0];
                    if (b_zero || overflow) begin
                        res_q   <= special_res;
                        state_q <= DONE;
                    end else begin
                        dvd_vld_q <= 1'b1;
                        dvs_vld_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                // Valids only drop on their own handshake, even when flushed.
                ISSUE, WAIT, DRAIN: begin
                    dvd_vld_q <= dvd_left;
                    dvs_vld_q <= dvs_left;
                    if (hs_done && div_dout_tvalid) begin
                        if (!drain) res_q <= core_res;
                        state_q <= drain ? IDLE : DONE;
                    end else begin
                        state_q <= drain ? DRAIN : (hs_done ? WAIT : ISSUE);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall = capture || (state_q == ISSUE) || (state_q == WAIT)
                 || ((state_q == DRAIN) && ex_valid);
    assign wb_valid            = (state_q == DONE) && !flush;
    assign wb_result           = res_q;
    assign div_signed          = signed_q;
    assign div_dividend_tvalid = dvd_vld_q;
    assign div_divisor_tvalid  = dvs_vld_q;
    assign div_dividend_tdata  = a_q;
    assign div_divisor_tdata   = b_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench with a result scoreboard for div_issue_ctrl.
module tb_div_issue_ctrl;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ex_valid = 1'b0;
    logic [2:0]        funct3 = '0;
    logic [XLEN-1:0]   a = '0, b = '0;
    logic              flush = 1'b0;
    logic              stall, wb_valid, div_signed;
    logic [XLEN-1:0]   wb_result;
    logic              div_dividend_tvalid, div_divisor_tvalid;
    logic [XLEN-1:0]   div_dividend_tdata, div_divisor_tdata;
    logic              div_dividend_tready = 1'b0, div_divisor_tready = 1'b0;
    logic              div_dout_tvalid = 1'b0;
    logic [2*XLEN-1:0] div_dout_tdata = '0;

    int passed = 0, failed = 0, total = 0, nwb = 0;
    logic [XLEN-1:0] exp_q[$];

    div_issue_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .funct3(funct3),
        .a(a), .b(b), .flush(flush), .stall(stall), .wb_valid(wb_valid),
        .wb_result(wb_result), .div_signed(div_signed),
        .div_dividend_tvalid(div_dividend_tvalid), .div_divisor_tvalid(div_divisor_tvalid),
        .div_dividend_tdata(div_dividend_tdata), .div_divisor_tdata(div_divisor_tdata),
        .div_dividend_tready(div_dividend_tready), .div_divisor_tready(div_divisor_tready),
        .div_dout_tvalid(div_dout_tvalid), .div_dout_tdata(div_dout_tdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a divide-class op for one capture edge, then withdraw it.
    task automatic op(input logic [2:0] f, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        ex_valid = 1'b1;
        funct3   = f;
        a        = x;
        b        = y;
        #1 chk("cap_stall", stall, 1'b1);
        tick();
        ex_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (wb_valid) begin
            nwb++;
            if (exp_q.size() == 0) chk("wb_spurious", wb_valid, 1'b0);
            else chk("wb_result", wb_result, exp_q.pop_front());
        end
    end

    initial begin
        #2;
        chk("rst_ctl", {stall, wb_valid, div_signed, div_dividend_tvalid, div_divisor_tvalid}, 5'b0);
        chk("rst_data", {div_dividend_tdata, div_divisor_tdata}, 64'd0);
        chk("rst_res", wb_result, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // signed DIV through the core, readies always high
        div_dividend_tready = 1'b1;
        div_divisor_tready  = 1'b1;
        exp_q.push_back(32'hFFFFFFFA);
        op(3'b100, 32'hFFFFFFEC, 32'd3);
        #1 chk("div_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b11);
        chk("div_tdata", {div_dividend_tdata, div_divisor_tdata}, {32'hFFFFFFEC, 32'd3});
        chk("div_signed", div_signed, 1'b1);
        tick();
        #1 chk("wait_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        chk("wait_stall", stall, 1'b1);
        tick();
        tick();
        #1 chk("wait_stall2", stall, 1'b1);
        div_dout_tvalid = 1'b1;
        div_dout_tdata  = {32'hFFFFFFFE, 32'hFFFFFFFA};
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("div_wbv", wb_valid, 1'b1);
        chk("done_stall", stall, 1'b0);
        tick();
        #1 chk("div_wbv_once", wb_valid, 1'b0);

        // locally resolved special cases
        exp_q.push_back(32'd7);
        op(3'b111, 32'd7, 32'd0);
        #1 chk("remu0_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        chk("remu0_wbv", wb_valid, 1'b1);
        tick();
        exp_q.push_back(32'hFFFFFFFF);
        op(3'b101, 32'd5, 32'd0);
        #1 chk("divu0_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        chk("divu0_wbv", wb_valid, 1'b1);
        tick();
        exp_q.push_back(32'd0);
        op(3'b110, 32'h80000000, 32'hFFFFFFFF);
        #1 chk("removf_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        chk("removf_wbv", wb_valid, 1'b1);
        tick();
        exp_q.push_back(32'h80000000);
        op(3'b100, 32'h80000000, 32'hFFFFFFFF);
        #1 chk("divovf_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        chk("divovf_wbv", wb_valid, 1'b1);
        tick();

        // REMU with handshakes on different cycles
        div_dividend_tready = 1'b0;
        div_divisor_tready  = 1'b0;
        exp_q.push_back(32'd2);
        op(3'b111, 32'd100, 32'd7);
        #1 chk("split_tvalid0", {div_dividend_tvalid, div_divisor_tvalid}, 2'b11);
        chk("remu_unsigned", div_signed, 1'b0);
        div_dividend_tready = 1'b1;
        tick();
        div_dividend_tready = 1'b0;
        #1 chk("split_tvalid1", {div_dividend_tvalid, div_divisor_tvalid}, 2'b01);
        chk("split_tdata", div_divisor_tdata, 32'd7);
        tick();
        #1 chk("split_tvalid2", {div_dividend_tvalid, div_divisor_tvalid}, 2'b01);
        div_divisor_tready = 1'b1;
        tick();
        div_divisor_tready = 1'b0;
        #1 chk("split_tvalid3", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        chk("split_stall", stall, 1'b1);
        div_dout_tvalid = 1'b1;
        div_dout_tdata  = {32'd2, 32'd14};
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("split_wbv", wb_valid, 1'b1);
        tick();

        // result arriving in the same cycle as both handshakes
        div_dividend_tready = 1'b1;
        div_divisor_tready  = 1'b1;
        exp_q.push_back(32'd10);
        op(3'b100, 32'd50, 32'd5);
        div_dout_tvalid = 1'b1;
        div_dout_tdata  = {32'd0, 32'd10};
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("fast_wbv", wb_valid, 1'b1);
        tick();

        // flush in WAIT, drained result discarded, then DIVU 10/3
        op(3'b101, 32'd9, 32'd2);
        tick();
        flush = 1'b1;
        #1 chk("flush_stall", stall, 1'b1);
        tick();
        flush    = 1'b0;
        ex_valid = 1'b1;
        funct3   = 3'b101;
        a        = 32'd10;
        b        = 32'd3;
        #1 chk("drain_stall", stall, 1'b1);
        chk("drain_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        div_dout_tvalid = 1'b1;
        div_dout_tdata  = {32'd1, 32'd4};
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("drain_wbv", wb_valid, 1'b0);
        chk("idle_cap_stall", stall, 1'b1);
        exp_q.push_back(32'd3);
        tick();
        ex_valid = 1'b0;
        #1 chk("post_tvalid", {div_dividend_tvalid, div_divisor_tvalid}, 2'b11);
        chk("post_tdata", div_dividend_tdata, 32'd10);
        tick();
        div_dout_tvalid = 1'b1;
        div_dout_tdata  = {32'd1, 32'd3};
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("post_wbv", wb_valid, 1'b1);
        tick();

        // flush in ISSUE keeps valids until accepted
        div_dividend_tready = 1'b0;
        div_divisor_tready  = 1'b0;
        op(3'b100, 32'd30, 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("drain_hold", {div_dividend_tvalid, div_divisor_tvalid}, 2'b11);
        chk("drain_nostall", stall, 1'b0);
        div_dividend_tready = 1'b1;
        div_divisor_tready  = 1'b1;
        tick();
        #1 chk("drain_acc", {div_dividend_tvalid, div_divisor_tvalid}, 2'b00);
        div_dout_tvalid = 1'b1;
        div_dout_tdata  = {32'd2, 32'd7};
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("drain2_wbv", wb_valid, 1'b0);
        tick();

        // flush in DONE suppresses the writeback
        op(3'b111, 32'd7, 32'd0);
        flush = 1'b1;
        #1 chk("done_flush_wbv", wb_valid, 1'b0);
        tick();
        flush = 1'b0;
        #1 chk("done_flush_after", wb_valid, 1'b0);

        // non-divide op, flushed op, stray result: all ignored in IDLE
        ex_valid = 1'b1;
        funct3   = 3'b000;
        #1 chk("nondiv_stall", stall, 1'b0);
        tick();
        ex_valid = 1'b0;
        #1 chk("nondiv_tvalid", {div_dividend_tvalid, div_divisor_tvalid, wb_valid}, 3'b000);
        ex_valid = 1'b1;
        funct3   = 3'b100;
        flush    = 1'b1;
        #1 chk("idle_flush_stall", stall, 1'b0);
        tick();
        ex_valid = 1'b0;
        flush    = 1'b0;
        #1 chk("idle_flush_tvalid", {div_dividend_tvalid, div_divisor_tvalid, wb_valid}, 3'b000);
        div_dout_tvalid = 1'b1;
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("idle_dout_wbv", wb_valid, 1'b0);

        // asynchronous reset while waiting on the core
        op(3'b100, 32'd40, 32'd6);
        tick();
        #2 reset_n = 1'b0;
        #1 chk("arst_ctl", {stall, wb_valid, div_signed, div_dividend_tvalid, div_divisor_tvalid}, 5'b0);
        chk("arst_data", {div_dividend_tdata, div_divisor_tdata}, 64'd0);
        chk("arst_res", wb_result, 32'd0);
        tick();
        reset_n         = 1'b1;
        div_dout_tvalid = 1'b1;
        div_dout_tdata  = {32'd4, 32'd6};
        tick();
        tick();
        div_dout_tvalid = 1'b0;
        #1 chk("stale_wbv", wb_valid, 1'b0);
        chk("stale_stall", stall, 1'b0);
        exp_q.push_back(32'd9);
        op(3'b111, 32'd9, 32'd0);
        #1 chk("recover_wbv", wb_valid, 1'b1);
        tick();

        #1 chk("sb_empty", exp_q.size(), 0);
        chk("wb_count", nwb, 9);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
